w_stage: RTL and testbench
==========================

// Module: w_stage
// PURPOSE
//   Write-back stage of the 5-stage MIPS pipeline: M/W pipeline register, load-data
//   extension, write-data select. Drives the register file write port (A3/WD/RFWr/PC)
//   and the W-stage forwarding source, and counts retired instructions.
//   Sits between the memory stage and the register file.
// PARAMETERS
//   DW      32  datapath width (PC, ALU result, memory word, write data)
//   CNT_W   32  width of the retired-instruction counter
// PORTS
//   Clk           in   1      clock, rising edge
//   Reset         in   1      synchronous, active-high
//   En            in   1      1: M/W register loads; 0: hold contents
//   Flush         in   1      1: load a bubble instead of M inputs
//   M_Valid       in   1      M stage holds a real instruction
//   M_PC          in   DW     PC of the M-stage instruction
//   M_A3          in   5      destination register
//   M_RFWr        in   1      instruction writes a register
//   M_WDSel       in   2      0 ALU, 1 DM, 2 PC+8, 3 reserved
//   M_ALUResult   in   DW     ALU result / effective address
//   M_DMRead      in   DW     raw aligned word read from data memory
//   M_LoadType    in   3      0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5-7 reserved
//   W_A3          out  5      RF write address
//   W_WD          out  DW     RF write data
//   W_RFWr        out  1      RF write enable
//   W_PC          out  DW     PC of W instruction, for the RF write trace
//   W_Valid       out  1      W stage holds a real instruction
//   W_FwdValid    out  1      forwarding source valid (= W_RFWr)
//   W_RetireCnt   out  CNT_W  instructions retired since reset
// BEHAVIOUR
//   - All state is updated on posedge Clk. Priority: Reset > Flush > !En > load.
//   - Reset: every M/W field and W_RetireCnt become 0. Outputs are then A3=0, WD=0,
//     RFWr=0, PC=0, Valid=0, FwdValid=0.
//   - Flush: loads a bubble. Valid=0, RFWr=0, A3=0, and all other fields 0.
//     Flush takes effect even when En=0.
//   - En=0 without Flush: every field holds its value. Outputs stay stable.
//   - Load: every M_* field is captured. Latency is 1 cycle from M inputs to W outputs.
//   - Outputs are combinational from registered fields only; there is no path from
//     M_* inputs to W_* outputs.
//   - W_RFWr = Valid & RFWr & (A3 != 0). A write to $0 is never asserted.
//   - W_WD select: 0 -> ALUResult; 1 -> extended DM data; 2 -> PC + 8 (mod 2^DW);
//     3 -> 0.
//   - Load extension uses off = ALUResult[1:0] (little-endian byte lanes):
//       LW: the whole word; off is ignored.
//       LB/LBU: byte DMRead[8*off +: 8], sign- or zero-extended.
//       LH/LHU: half DMRead[16*off[1] +: 16], sign- or zero-extended; off[0] is ignored.
//       Reserved types: result 0.
//   - W_RetireCnt increments by 1 on each cycle where the register currently holds
//     Valid=1 and the next edge loads new contents (En=1 or Flush=1).
//       A held instruction (En=0, no Flush) is counted once, when it leaves.
//       The counter wraps from 2^CNT_W-1 to 0.
//   - Reset mid-operation discards the in-flight instruction without counting it,
//     and forces W_RFWr low from the next cycle.
// STRUCTURE
//   - Shared defines header (mips_defs) holds:
//       WDSel codes WD_ALU/WD_DM/WD_PC8
//       LoadType codes LT_LW/LT_LB/LT_LBU/LT_LH/LT_LHU
//   - Sub-module load_ext: combinational extender
//       inputs: DMRead, off, LoadType
//       output: ext data
//   - The M/W register, write-data mux and counter live in w_stage.
// TESTING
//   1. Reset held 2 cycles -> all outputs 0, W_RetireCnt=0, W_RFWr=0.
//   2. ALU writeback: M_A3=5, M_RFWr=1, WDSel=0, ALUResult=32'h1234_5678, En=1
//      -> next cycle W_A3=5, W_WD=32'h1234_5678, W_RFWr=1; RetireCnt=1 after the following edge.
//   3. Loads, DMRead=32'h80FF_7F01:
//      LB off=3 -> FFFF_FF80; LBU off=3 -> 0000_0080; LH off=2 -> FFFF_80FF;
//      LHU off=0 -> 0000_7F01; LW off=1 -> 80FF_7F01.
//   4. JAL-style write: WDSel=2, M_PC=32'h0000_3000, A3=31 -> W_WD=32'h0000_3008.
//      Same instruction with A3=0 -> W_RFWr=0.
//   5. En=0 for 3 cycles with a valid instruction in W -> outputs constant and
//      RetireCnt unchanged. Release -> count +1 once.
//   6. Flush together with En=0 -> bubble (W_Valid=0, W_RFWr=0).
//      Reset asserted while W_RFWr=1 -> W_RFWr=0 next cycle, RetireCnt=0.

Source files
------------

// File: rtl/w_stage_pkg.sv
// Shared MIPS pipeline encodings used by the write-back stage.
// Holds the write-data select codes and the load-type codes.
package w_stage_pkg;

    // Write-data select codes (M_WDSel / W-stage mux)
    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_DM  = 2'd1;
    localparam logic [1:0] WD_PC8 = 2'd2;

    // Load-type codes; 5..7 are reserved and extend to zero
    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

endpackage

// File: rtl/w_stage_load_ext.sv
// Combinational load extender: picks the byte/half lane of an aligned
// little-endian memory word and sign- or zero-extends it to DW bits.
module load_ext
    import w_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] DMRead,
    input  logic [1:0]    off,
    input  logic [2:0]    LoadType,
    output logic [DW-1:0] ext
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection: byte by full offset, half by offset bit 1 only
    always_comb begin
        byte_s = 8'h00;
        case (off)
            2'd0:    byte_s = DMRead[7:0];
            2'd1:    byte_s = DMRead[15:8];
            2'd2:    byte_s = DMRead[23:16];
            2'd3:    byte_s = DMRead[31:24];
            default: byte_s = 8'h00;
        endcase
        if (off[1]) begin
            half_s = DMRead[31:16];
        end else begin
            half_s = DMRead[15:0];
        end
    end

    // Extension by load type; reserved types produce zero
    always_comb begin
        ext = {DW{1'b0}};
        case (LoadType)
            LT_LW:   ext = DMRead;
            LT_LB:   ext = {{(DW-8){byte_s[7]}}, byte_s};
            LT_LBU:  ext = {{(DW-8){1'b0}}, byte_s};
            LT_LH:   ext = {{(DW-16){half_s[15]}}, half_s};
            LT_LHU:  ext = {{(DW-16){1'b0}}, half_s};
            default: ext = {DW{1'b0}};
        endcase
    end

endmodule

// File: rtl/w_stage.sv
// MIPS write-back stage: M/W pipeline register, write-data select,
// register-file write port drive and retired-instruction counter.
// W outputs depend only on registered fields (no M->W combinational path).
module w_stage
    import w_stage_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Flush,
    input  logic             M_Valid,
    input  logic [DW-1:0]    M_PC,
    input  logic [4:0]       M_A3,
    input  logic             M_RFWr,
    input  logic [1:0]       M_WDSel,
    input  logic [DW-1:0]    M_ALUResult,
    input  logic [DW-1:0]    M_DMRead,
    input  logic [2:0]       M_LoadType,
    output logic [4:0]       W_A3,
    output logic [DW-1:0]    W_WD,
    output logic             W_RFWr,
    output logic [DW-1:0]    W_PC,
    output logic             W_Valid,
    output logic             W_FwdValid,
    output logic [CNT_W-1:0] W_RetireCnt
);

    logic             valid_q, valid_d;
    logic [DW-1:0]    pc_q, pc_d;
    logic [4:0]       a3_q, a3_d;
    logic             rfwr_q, rfwr_d;
    logic [1:0]       wdsel_q, wdsel_d;
    logic [DW-1:0]    alu_q, alu_d;
    logic [DW-1:0]    dm_q, dm_d;
    logic [2:0]       lt_q, lt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DW-1:0]    ext_s;
    logic [DW-1:0]    wd_s;
    logic             advance_s;

    // A new load (instruction or bubble) happens on Flush or En
    assign advance_s = Flush | En;

    // M/W next state: Flush loads a bubble, En loads M, otherwise hold
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        a3_d    = a3_q;
        rfwr_d  = rfwr_q;
        wdsel_d = wdsel_q;
        alu_d   = alu_q;
        dm_d    = dm_q;
        lt_d    = lt_q;
        if (Flush) begin
            valid_d = 1'b0;
            pc_d    = {DW{1'b0}};
            a3_d    = 5'd0;
            rfwr_d  = 1'b0;
            wdsel_d = 2'd0;
            alu_d   = {DW{1'b0}};
            dm_d    = {DW{1'b0}};
            lt_d    = 3'd0;
        end else if (En) begin
            valid_d = M_Valid;
            pc_d    = M_PC;
            a3_d    = M_A3;
            rfwr_d  = M_RFWr;
            wdsel_d = M_WDSel;
            alu_d   = M_ALUResult;
            dm_d    = M_DMRead;
            lt_d    = M_LoadType;
        end else begin
            valid_d = valid_q;
        end
    end

    // Retire count: a valid instruction is counted once, when it leaves W
    always_comb begin
        if (valid_q && advance_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset (reset drops in-flight work uncounted)
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q <= 1'b0;
            pc_q    <= {DW{1'b0}};
            a3_q    <= 5'd0;
            rfwr_q  <= 1'b0;
            wdsel_q <= 2'd0;
            alu_q   <= {DW{1'b0}};
            dm_q    <= {DW{1'b0}};
            lt_q    <= 3'd0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            a3_q    <= a3_d;
            rfwr_q  <= rfwr_d;
            wdsel_q <= wdsel_d;
            alu_q   <= alu_d;
            dm_q    <= dm_d;
            lt_q    <= lt_d;
            cnt_q   <= cnt_d;
        end
    end

    load_ext #(
        .DW(DW)
    ) u_load_ext (
        .DMRead   (dm_q),
        .off      (alu_q[1:0]),
        .LoadType (lt_q),
        .ext      (ext_s)
    );

    // Write-data select from registered fields; code 3 yields zero
    always_comb begin
        wd_s = {DW{1'b0}};
        case (wdsel_q)
            WD_ALU:  wd_s = alu_q;
            WD_DM:   wd_s = ext_s;
            WD_PC8:  wd_s = pc_q + {{(DW-4){1'b0}}, 4'd8};
            default: wd_s = {DW{1'b0}};
        endcase
    end

    assign W_A3        = a3_q;
    assign W_WD        = wd_s;
    assign W_RFWr      = valid_q & rfwr_q & (a3_q != 5'd0);
    assign W_FwdValid  = W_RFWr;
    assign W_PC        = pc_q;
    assign W_Valid     = valid_q;
    assign W_RetireCnt = cnt_q;

endmodule

// File: tb/tb_w_stage.sv
// Directed self-checking bench for the MIPS write-back stage.
module tb_w_stage;

    logic        Clk = 1'b0;
    logic        Reset, En, Flush, M_Valid, M_RFWr;
    logic [31:0] M_PC, M_ALUResult, M_DMRead;
    logic [4:0]  M_A3;
    logic [1:0]  M_WDSel;
    logic [2:0]  M_LoadType;
    logic [4:0]  W_A3;
    logic [31:0] W_WD, W_PC, W_RetireCnt;
    logic        W_RFWr, W_Valid, W_FwdValid;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic        w_valid_m = 1'b0;

    w_stage #(.DW(32), .CNT_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .Flush(Flush),
        .M_Valid(M_Valid), .M_PC(M_PC), .M_A3(M_A3), .M_RFWr(M_RFWr),
        .M_WDSel(M_WDSel), .M_ALUResult(M_ALUResult), .M_DMRead(M_DMRead),
        .M_LoadType(M_LoadType),
        .W_A3(W_A3), .W_WD(W_WD), .W_RFWr(W_RFWr), .W_PC(W_PC),
        .W_Valid(W_Valid), .W_FwdValid(W_FwdValid), .W_RetireCnt(W_RetireCnt)
    );

    always #5 Clk = ~Clk;

    // Advance one clock; expected retire count tracked from the inputs at the edge
    task automatic step();
        if (Reset) begin
            exp_cnt   = 32'd0;
            w_valid_m = 1'b0;
        end else if (Flush) begin
            if (w_valid_m) exp_cnt = exp_cnt + 32'd1;
            w_valid_m = 1'b0;
        end else if (En) begin
            if (w_valid_m) exp_cnt = exp_cnt + 32'd1;
            w_valid_m = M_Valid;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] a3,
                         input logic rfwr, input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] dm, input logic [2:0] lt);
        M_Valid = v; M_PC = pc; M_A3 = a3; M_RFWr = rfwr;
        M_WDSel = sel; M_ALUResult = alu; M_DMRead = dm; M_LoadType = lt;
    endtask

    task automatic test_reset();
        Reset = 1'b1; En = 1'b1; Flush = 1'b0;
        drive(1'b1, 32'h0000_4000, 5'd3, 1'b1, 2'd0, 32'hDEAD_BEEF, 32'h0, 3'd0);
        step(); step();
        total++; if (W_A3 !== 5'd0) begin bad++; $display("FAIL reset_a3: got %0d want 0", W_A3); end
        total++; if (W_WD !== 32'd0) begin bad++; $display("FAIL reset_wd: got %h want 0", W_WD); end
        total++; if (W_RFWr !== 1'b0) begin bad++; $display("FAIL reset_rfwr: got %b want 0", W_RFWr); end
        total++; if (W_PC !== 32'd0) begin bad++; $display("FAIL reset_pc: got %h want 0", W_PC); end
        total++; if (W_Valid !== 1'b0 || W_FwdValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b/%b want 0/0", W_Valid, W_FwdValid); end
        total++; if (W_RetireCnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", W_RetireCnt); end
        Reset = 1'b0;
    endtask

    task automatic test_alu();
        drive(1'b1, 32'h0000_1000, 5'd5, 1'b1, 2'd0, 32'h1234_5678, 32'h0, 3'd0);
        step();
        total++; if (W_A3 !== 5'd5) begin bad++; $display("FAIL alu_a3: got %0d want 5", W_A3); end
        total++; if (W_WD !== 32'h1234_5678) begin bad++; $display("FAIL alu_wd: got %h want 12345678", W_WD); end
        total++; if (W_RFWr !== 1'b1 || W_FwdValid !== 1'b1) begin bad++; $display("FAIL alu_rfwr: got %b/%b want 1/1", W_RFWr, W_FwdValid); end
        total++; if (W_PC !== 32'h0000_1000) begin bad++; $display("FAIL alu_pc: got %h want 00001000", W_PC); end
        total++; if (W_RetireCnt !== 32'd0) begin bad++; $display("FAIL alu_cnt0: got %0d want 0", W_RetireCnt); end
        drive(1'b0, 32'h0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 3'd0);
        step();
        total++; if (W_RetireCnt !== 32'd1) begin bad++; $display("FAIL alu_cnt1: got %0d want 1", W_RetireCnt); end
        total++; if (W_Valid !== 1'b0 || W_RFWr !== 1'b0) begin bad++; $display("FAIL alu_bubble: got %b/%b want 0/0", W_Valid, W_RFWr); end
    endtask

    task automatic test_loads();
        logic [2:0]  lt_v  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd5};
        logic [1:0]  off_v [6] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd0};
        logic [31:0] exp_v [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                   32'h0000_7F01, 32'h80FF_7F01, 32'h0000_0000};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h0000_2000, 5'd8, 1'b1, 2'd1, {30'h0000_0400, off_v[i]},
                  32'h80FF_7F01, lt_v[i]);
            step();
            total++;
            if (W_WD !== exp_v[i]) begin
                bad++; $display("FAIL load_%0d: got %h want %h", i, W_WD, exp_v[i]);
            end
        end
        drive(1'b1, 32'h0000_2000, 5'd8, 1'b1, 2'd3, 32'h5555_5555, 32'h0, 3'd0);
        step();
        total++; if (W_WD !== 32'd0) begin bad++; $display("FAIL wdsel3: got %h want 0", W_WD); end
        total++; if (W_RetireCnt !== exp_cnt) begin bad++; $display("FAIL load_cnt: got %0d want %0d", W_RetireCnt, exp_cnt); end
    endtask

    task automatic test_jal();
        drive(1'b1, 32'h0000_3000, 5'd31, 1'b1, 2'd2, 32'h0, 32'h0, 3'd0);
        step();
        total++; if (W_WD !== 32'h0000_3008) begin bad++; $display("FAIL jal_wd: got %h want 00003008", W_WD); end
        total++; if (W_RFWr !== 1'b1 || W_A3 !== 5'd31) begin bad++; $display("FAIL jal_wr: got %b a3=%0d want 1 a3=31", W_RFWr, W_A3); end
        drive(1'b1, 32'h0000_3000, 5'd0, 1'b1, 2'd2, 32'h0, 32'h0, 3'd0);
        step();
        total++; if (W_RFWr !== 1'b0 || W_FwdValid !== 1'b0) begin bad++; $display("FAIL jal_r0: got %b/%b want 0/0", W_RFWr, W_FwdValid); end
        total++; if (W_Valid !== 1'b1) begin bad++; $display("FAIL jal_r0_valid: got %b want 1", W_Valid); end
        drive(1'b1, 32'hFFFF_FFFC, 5'd31, 1'b1, 2'd2, 32'h0, 32'h0, 3'd0);
        step();
        total++; if (W_WD !== 32'h0000_0004) begin bad++; $display("FAIL jal_wrap: got %h want 00000004", W_WD); end
    endtask

    task automatic test_stall();
        logic [31:0] c0;
        drive(1'b1, 32'h0000_5000, 5'd7, 1'b1, 2'd0, 32'hAAAA_5555, 32'h0, 3'd0);
        step();
        c0 = exp_cnt;
        En = 1'b0;
        drive(1'b1, 32'h0000_6000, 5'd9, 1'b0, 2'd2, 32'h1111_1111, 32'h0, 3'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (W_A3 !== 5'd7 || W_WD !== 32'hAAAA_5555 || W_RFWr !== 1'b1 || W_PC !== 32'h0000_5000) begin
                bad++; $display("FAIL stall_hold_%0d: got a3=%0d wd=%h wr=%b pc=%h want 7 aaaa5555 1 00005000",
                                i, W_A3, W_WD, W_RFWr, W_PC);
            end
            total++;
            if (W_RetireCnt !== c0) begin bad++; $display("FAIL stall_cnt_%0d: got %0d want %0d", i, W_RetireCnt, c0); end
        end
        En = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 3'd0);
        step();
        total++; if (W_RetireCnt !== c0 + 32'd1) begin bad++; $display("FAIL stall_release: got %0d want %0d", W_RetireCnt, c0 + 32'd1); end
        step();
        total++; if (W_RetireCnt !== c0 + 32'd1) begin bad++; $display("FAIL stall_once: got %0d want %0d", W_RetireCnt, c0 + 32'd1); end
    endtask

    task automatic test_flush_reset();
        logic [31:0] c0;
        drive(1'b1, 32'h0000_7000, 5'd9, 1'b1, 2'd0, 32'h0BAD_F00D, 32'h0, 3'd0);
        step();
        c0 = exp_cnt;
        En = 1'b0; Flush = 1'b1;
        step();
        Flush = 1'b0; En = 1'b1;
        total++; if (W_Valid !== 1'b0 || W_RFWr !== 1'b0) begin bad++; $display("FAIL flush_bubble: got %b/%b want 0/0", W_Valid, W_RFWr); end
        total++; if (W_A3 !== 5'd0 || W_WD !== 32'd0 || W_PC !== 32'd0) begin bad++; $display("FAIL flush_fields: got a3=%0d wd=%h pc=%h want zeros", W_A3, W_WD, W_PC); end
        total++; if (W_RetireCnt !== c0 + 32'd1) begin bad++; $display("FAIL flush_cnt: got %0d want %0d", W_RetireCnt, c0 + 32'd1); end
        step();
        total++; if (W_RFWr !== 1'b1) begin bad++; $display("FAIL pre_reset_wr: got %b want 1", W_RFWr); end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        total++; if (W_RFWr !== 1'b0 || W_Valid !== 1'b0) begin bad++; $display("FAIL reset_mid_wr: got %b/%b want 0/0", W_RFWr, W_Valid); end
        total++; if (W_RetireCnt !== 32'd0) begin bad++; $display("FAIL reset_mid_cnt: got %0d want 0", W_RetireCnt); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_jal();
        test_stall();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
